cisr_row_scheduler: RTL and testbench

//  Row-slot scheduler for the CISR SpMV front end. Pulls row lengths from the row-length stream in CISR order.

---
 rtl/cisr_pkg.sv | 19 +
 rtl/cisr_channel_slot.sv | 63 ++++++
 rtl/cisr_row_scheduler.sv | 173 +++++++++++++++++
 tb/tb_cisr_row_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cisr_pkg.sv
// Shared types and defaults for the CISR row scheduler.
// - row_id_t / len_t : default-width row ID and row-length types
// - sched_state_e    : scheduler FSM states (IDLE, RUN, FIN)
package cisr_pkg;

  localparam int CISR_CHANNELS = 16;
  localparam int CISR_ROW_W    = 32;
  localparam int CISR_LEN_W    = 16;

  typedef logic [CISR_ROW_W-1:0] row_id_t;
  typedef logic [CISR_LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/cisr_channel_slot.sv
// One channel slot of the CISR row scheduler: holds the row ID bound to the
// channel and a down-counter of that row's outstanding nonzeros.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   bind_en        : load bind_len / bind_id (only asserted while the slot is free)
//   bind_len       : nonzeros in the bound row
//   bind_id        : row ID of the bound row
//   elem_valid     : channel presents a nonzero
//   elem_ready     : slot has nonzeros outstanding (remaining != 0)
//   row_last       : the outstanding nonzero is the last one of the row
//   row_id         : row ID currently bound to the slot
module cisr_channel_slot
  import cisr_pkg::*;
#(
  parameter int ROW_W = CISR_ROW_W,
  parameter int LEN_W = CISR_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bind_en,
  input  logic [LEN_W-1:0] bind_len,
  input  logic [ROW_W-1:0] bind_id,
  input  logic             elem_valid,
  output logic             elem_ready,
  output logic             row_last,
  output logic [ROW_W-1:0] row_id
);

  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [ROW_W-1:0] row_id_q, row_id_d;

  assign elem_ready = (remaining_q != '0);
  assign row_last   = elem_ready && (remaining_q == LEN_W'(1));
  assign row_id     = row_id_q;

  // NOTE: every signal written in always_comb gets its default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    remaining_d = remaining_q;
    row_id_d    = row_id_q;
    // A bind only ever targets a free slot, so it never collides with a
    // decrement (a free slot is not ready).
    if (bind_en) begin
      remaining_d = bind_len;
      row_id_d    = bind_id;
    end else if (elem_valid && elem_ready) begin
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
      row_id_q    <= '0;
    end else begin
      remaining_q <= remaining_d;
      row_id_q    <= row_id_d;
    end
  end

endmodule

// File: rtl/cisr_row_scheduler.sv
// CISR row-slot scheduler. Accepts row lengths in CISR order, binds each row
// to the lowest-index idle channel with the next sequential row ID, and lets
// each channel count down its row's nonzeros with a last-in-row tag.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, num_rows          : begin a matrix of num_rows rows (sampled in IDLE)
//   rl_valid/rl_data/rl_ready: row-length stream
//   ch_elem_valid/ready      : per-channel nonzero handshake
//   ch_row_id, ch_row_last   : per-channel row ID and last-in-row flag
//   busy, done               : FSM not idle / one-cycle completion pulse
// Configuration macro CISR_EMPTY_ROW_EN:
//   defined   -> empty_valid / empty_id report zero-length rows
//   undefined -> sticky err flags zero-length rows (cleared on start)
module cisr_row_scheduler
  import cisr_pkg::*;
#(
  parameter int CHANNELS = CISR_CHANNELS,
  parameter int ROW_W    = CISR_ROW_W,
  parameter int LEN_W    = CISR_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ROW_W-1:0]          num_rows,
  input  logic                      rl_valid,
  input  logic [LEN_W-1:0]          rl_data,
  output logic                      rl_ready,
  input  logic [CHANNELS-1:0]       ch_elem_valid,
  output logic [CHANNELS-1:0]       ch_elem_ready,
  output logic [CHANNELS*ROW_W-1:0] ch_row_id,
  output logic [CHANNELS-1:0]       ch_row_last,
  output logic                      busy,
`ifdef CISR_EMPTY_ROW_EN
  output logic                      empty_valid,
  output logic [ROW_W-1:0]          empty_id,
`else
  output logic                      err,
`endif
  output logic                      done
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  sched_state_e     state_q, state_d;
  logic [ROW_W-1:0] rows_total_q, rows_total_d;
  logic [ROW_W-1:0] next_row_q, next_row_d;
  logic [ROW_W-1:0] issued_q, issued_d;
`ifdef CISR_EMPTY_ROW_EN
  logic             empty_valid_q, empty_valid_d;
  logic [ROW_W-1:0] empty_id_q, empty_id_d;
`else
  logic             err_q, err_d;
`endif

  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                rl_fire;
  logic                zero_len;
  logic [CHANNELS-1:0] bind_vec;

  // Lowest-index free slot: scan downwards so the lowest hit is written last.
  // Freeness comes from registered counters, so a slot freed this cycle is
  // only grantable next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (!ch_elem_ready[c]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(c);
      end
    end
  end

  assign rl_ready = (state_q == RUN) && (issued_q < rows_total_q) && free_found;
  assign rl_fire  = rl_valid && rl_ready;
  assign zero_len = (rl_data == '0);

  always_comb begin
    bind_vec = '0;
    if (rl_fire && !zero_len) bind_vec[free_idx] = 1'b1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    cisr_channel_slot #(
      .ROW_W(ROW_W),
      .LEN_W(LEN_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .bind_en   (bind_vec[c]),
      .bind_len  (rl_data),
      .bind_id   (next_row_q),
      .elem_valid(ch_elem_valid[c]),
      .elem_ready(ch_elem_ready[c]),
      .row_last  (ch_row_last[c]),
      .row_id    (ch_row_id[c*ROW_W +: ROW_W])
    );
  end

  always_comb begin
    state_d      = state_q;
    rows_total_d = rows_total_q;
    next_row_d   = next_row_q;
    issued_d     = issued_q;
`ifdef CISR_EMPTY_ROW_EN
    empty_valid_d = rl_fire && zero_len;
    empty_id_d    = (rl_fire && zero_len) ? next_row_q : empty_id_q;
`else
    err_d = err_q;
    if (rl_fire && zero_len) err_d = 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          rows_total_d = num_rows;
          next_row_d   = '0;
          issued_d     = '0;
`ifndef CISR_EMPTY_ROW_EN
          err_d        = 1'b0;
`endif
        end
      end
      RUN: begin
        // Zero-length rows still consume an ID and count as issued.
        if (rl_fire) begin
          next_row_d = next_row_q + ROW_W'(1);
          issued_d   = issued_q + ROW_W'(1);
        end
        if ((issued_q == rows_total_q) && !(|ch_elem_ready)) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rows_total_q  <= '0;
      next_row_q    <= '0;
      issued_q      <= '0;
`ifdef CISR_EMPTY_ROW_EN
      empty_valid_q <= 1'b0;
      empty_id_q    <= '0;
`else
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rows_total_q  <= rows_total_d;
      next_row_q    <= next_row_d;
      issued_q      <= issued_d;
`ifdef CISR_EMPTY_ROW_EN
      empty_valid_q <= empty_valid_d;
      empty_id_q    <= empty_id_d;
`else
      err_q         <= err_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);
`ifdef CISR_EMPTY_ROW_EN
  assign empty_valid = empty_valid_q;
  assign empty_id    = empty_id_q;
`else
  assign err = err_q;
`endif

endmodule

// File: tb/tb_cisr_row_scheduler.sv
// Self-checking bench for cisr_row_scheduler (4 channels, 16-bit IDs, 8-bit
// lengths). A behavioural model of slots/counters is compared against the
// DUT on every falling edge; directed scenarios add literal expectations.
module tb_cisr_row_scheduler;

  localparam int CH = 4;
  localparam int RW = 16;
  localparam int LW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [RW-1:0]    num_rows = '0;
  logic             rl_valid = 1'b0;
  logic [LW-1:0]    rl_data = '0;
  logic             rl_ready;
  logic [CH-1:0]    ch_elem_valid = '0;
  logic [CH-1:0]    ch_elem_ready;
  logic [CH*RW-1:0] ch_row_id;
  logic [CH-1:0]    ch_row_last;
  logic             busy;
  logic             done;
`ifdef CISR_EMPTY_ROW_EN
  logic             empty_valid;
  logic [RW-1:0]    empty_id;
`else
  logic             err;
`endif

  cisr_row_scheduler #(.CHANNELS(CH), .ROW_W(RW), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_rows     (num_rows),
    .rl_valid     (rl_valid),
    .rl_data      (rl_data),
    .rl_ready     (rl_ready),
    .ch_elem_valid(ch_elem_valid),
    .ch_elem_ready(ch_elem_ready),
    .ch_row_id    (ch_row_id),
    .ch_row_last  (ch_row_last),
    .busy         (busy),
`ifdef CISR_EMPTY_ROW_EN
    .empty_valid  (empty_valid),
    .empty_id     (empty_id),
`else
    .err          (err),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int ch; int id; bit last;} ev_t;
  ev_t ev_log[$];
  int  m_state;            // 0 idle, 1 run, 2 fin
  int  m_rem[CH];
  int  m_id[CH];
  int  m_total, m_issued, m_next;
  bit  m_err, m_ev;
  int  m_eid;
  int  row_len[int];
  int  row_seen[int];
  int  done_cnt = 0;
  int  last_empty_id = -1;

  task automatic model_reset();
    m_state = 0; m_total = 0; m_issued = 0; m_next = 0;
    m_err = 0; m_ev = 0; m_eid = 0;
    for (int c = 0; c < CH; c++) begin m_rem[c] = 0; m_id[c] = 0; end
  endtask

  always @(negedge clk) begin : compare
    bit anyf, fire, all0;
    int f, issued_pre;
    logic [CH-1:0] e_rdy, e_last;
    logic [CH*RW-1:0] e_ids;
    if (rst) begin
      model_reset();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rl_ready", rl_ready, 0);
      check("rst_elem_ready", ch_elem_ready, 0);
      check("rst_row_id", ch_row_id, 0);
    end else begin
      anyf = 0; f = 0;
      for (int c = CH - 1; c >= 0; c--) if (m_rem[c] == 0) begin anyf = 1; f = c; end
      for (int c = 0; c < CH; c++) begin
        e_rdy[c]  = (m_rem[c] != 0);
        e_last[c] = (m_rem[c] == 1);
        e_ids[c*RW +: RW] = RW'(m_id[c]);
      end
      check("busy", busy, m_state != 0);
      check("done", done, m_state == 2);
      check("rl_ready", rl_ready, (m_state == 1) && (m_issued < m_total) && anyf);
      check("elem_ready", ch_elem_ready, e_rdy);
      check("row_last", ch_row_last, e_last);
      check("row_id", ch_row_id, e_ids);
`ifdef CISR_EMPTY_ROW_EN
      check("empty_valid", empty_valid, m_ev);
      check("empty_id", empty_id, RW'(m_eid));
      if (empty_valid) last_empty_id = int'(empty_id);
`else
      check("err", err, m_err);
`endif
      if (done) done_cnt++;

      // advance the model by one clock edge
      fire = rl_valid && (m_state == 1) && (m_issued < m_total) && anyf;
      all0 = !anyf ? 0 : 1;
      for (int c = 0; c < CH; c++) if (m_rem[c] != 0) all0 = 0;
      issued_pre = m_issued;
      for (int c = 0; c < CH; c++) begin
        if (ch_elem_valid[c] && m_rem[c] != 0) begin
          ev_log.push_back('{c, m_id[c], m_rem[c] == 1});
          row_seen[m_id[c]] = row_seen.exists(m_id[c]) ? row_seen[m_id[c]] + 1 : 1;
          if (m_rem[c] == 1) check("row_elem_count", row_seen[m_id[c]], row_len[m_id[c]]);
          m_rem[c]--;
        end
      end
      m_ev = 0;
      if (fire) begin
        row_len[m_next] = int'(rl_data);
        if (rl_data != 0) begin
          m_rem[f] = int'(rl_data);
          m_id[f]  = m_next;
        end else begin
          m_err = 1; m_ev = 1; m_eid = m_next;
        end
        m_next++; m_issued++;
      end
      case (m_state)
        0: if (start) begin
          m_state = 1; m_total = int'(num_rows); m_next = 0; m_issued = 0; m_err = 0;
          row_len.delete(); row_seen.delete();
        end
        1: if (issued_pre == m_total && all0) m_state = 2;
        default: m_state = 0;
      endcase
    end
  end

  // ---------------- row-length feeder ----------------
  logic [LW-1:0] rl_q[$];

  initial begin : feeder
    bit fired;
    forever begin
      @(negedge clk);
      fired = rl_valid && rl_ready;
      @(posedge clk);
      #1;
      if (fired && rl_q.size() > 0) void'(rl_q.pop_front());
      rl_valid = (rl_q.size() > 0) && !rst;
      rl_data  = (rl_q.size() > 0) ? rl_q[0] : '0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_matrix(input int n);
    start = 1'b1;
    num_rows = RW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ev, input string name);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      tick();
      if (rand_ev) ch_elem_valid = CH'($urandom);
    end
    check(name, seen, 1);
  endtask

  int e_ch[6]   = '{0, 0, 1, 2, 2, 2};
  int e_id[6]   = '{0, 0, 1, 2, 2, 2};
  bit e_last[6] = '{0, 1, 1, 0, 0, 1};

  initial begin : main
    bit found8;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // rows {2,1,3}, every channel always accepting
    ch_elem_valid = '1;
    ev_log.delete();
    done_cnt = 0;
    rl_q = '{8'd2, 8'd1, 8'd3};
    start_matrix(3);
    wait_done(100, 0, "t2_done");
    tick(); tick();
    check("t2_done_once", done_cnt, 1);
    check("t2_log_size", ev_log.size(), 6);
    for (int i = 0; i < 6 && i < ev_log.size(); i++) begin
      check("t2_ev_ch", ev_log[i].ch, e_ch[i]);
      check("t2_ev_id", ev_log[i].id, e_id[i]);
      check("t2_ev_last", ev_log[i].last, e_last[i]);
    end

    // 7 rows of length 5, channels stalled: four grants then back-pressure
    ch_elem_valid = '0;
    for (int i = 0; i < 7; i++) rl_q.push_back(8'd5);
    start_matrix(7);
    repeat (8) tick();
    @(negedge clk);
    check("t3_rl_ready_low", rl_ready, 0);
    check("t3_ids", ch_row_id, {16'd3, 16'd2, 16'd1, 16'd0});
    tick();
    ch_elem_valid = 4'b0100;
    repeat (4) tick();
    @(negedge clk);
    check("t3_last_slot2", ch_row_last, 4'b0100);
    check("t3_no_same_cycle_rebind", rl_ready, 0);
    tick();
    ch_elem_valid = '0;
    @(negedge clk);
    check("t3_slot2_free", ch_elem_ready, 4'b1011);
    check("t3_rl_ready_back", rl_ready, 1);
    tick();
    @(negedge clk);
    check("t3_row4_slot2", ch_row_id[2*RW +: RW], 4);

    // slots 1 and 3 freed together: lowest index first
    tick();
    ch_elem_valid = 4'b1010;
    repeat (5) tick();
    ch_elem_valid = '0;
    @(negedge clk);
    check("t4_both_free", ch_elem_ready, 4'b0101);
    tick();
    @(negedge clk);
    check("t4_row5_slot1", ch_row_id[1*RW +: RW], 5);
    check("t4_slot3_still_free", ch_elem_ready, 4'b0111);
    tick();
    @(negedge clk);
    check("t4_row6_slot3", ch_row_id[3*RW +: RW], 6);
    tick();
    ch_elem_valid = '1;
    wait_done(100, 0, "t4_done");
    tick();

    // zero-length row 7; a start during RUN must be ignored
    ev_log.delete();
    for (int i = 0; i < 10; i++) rl_q.push_back((i == 7) ? 8'd0 : LW'($urandom_range(1, 4)));
    start_matrix(10);
    repeat (3) tick();
    start = 1'b1;
    num_rows = RW'(2);
    tick();
    start = 1'b0;
    wait_done(300, 1, "t5_done");
`ifdef CISR_EMPTY_ROW_EN
    check("t5_empty_id", last_empty_id, 7);
`else
    check("t5_err", err, 1);
`endif
    found8 = 0;
    foreach (ev_log[i]) if (ev_log[i].id == 8) found8 = 1;
    check("t5_row8_present", found8, 1);
    tick();

    // num_rows = 0: done two cycles after start
    start_matrix(0);
    @(negedge clk);
    check("t6_busy", busy, 1);
    check("t6_done_early", done, 0);
    tick();
    @(negedge clk);
    check("t6_done", done, 1);
    tick();
    @(negedge clk);
    check("t6_idle", busy, 0);
    tick();

    // randomized matrices
    for (int m = 0; m < 6; m++) begin
      int n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) rl_q.push_back(LW'($urandom_range(0, 6)));
      start_matrix(n);
      wait_done(600, 1, "rand_done");
      tick();
    end

    // reset mid-RUN with slots bound
    ch_elem_valid = '0;
    for (int i = 0; i < 8; i++) rl_q.push_back(8'd4);
    start_matrix(8);
    repeat (6) tick();
    rst = 1'b1;
    rl_q.delete();
    @(negedge clk);
    check("t1_elem_ready", ch_elem_ready, 0);
    check("t1_busy", busy, 0);
    check("t1_ids", ch_row_id, 0);
    tick();
    rst = 1'b0;
    tick();
    ch_elem_valid = '1;
    rl_q = '{8'd1, 8'd1};
    start_matrix(2);
    wait_done(100, 0, "t1_recover_done");
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
